// File: rtl/datapath_exec_unit_pkg.sv
// Shared encodings for the execution datapath: ALU op codes, operand-B select,
// multiplier FSM states and the immediate field-width table.
package datapath_exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_MUL = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_TWO  = 2'd2,
        SRCB_ZERO = 2'd3
    } srcb_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_state_e;

    localparam int IR_W = 16;

    function automatic logic [4:0] imm_width(input logic [1:0] num_bits);
        logic [4:0] w;
        case (num_bits)
            2'd0:    w = 5'd4;
            2'd1:    w = 5'd6;
            2'd2:    w = 5'd8;
            default: w = 5'd12;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/datapath_exec_unit_if.sv
// Control/data bundle between the control FSM (master) and the execution datapath (slave).
interface datapath_exec_unit_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       instruction;
    logic              instrWrite;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] dataWrite;
    logic              regWrite;
    logic              DOrS;
    logic              ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [3:0]        ALUOp;
    logic [1:0]        numBits;
    logic              immShift;
    logic              start;
    logic [DATA_W-1:0] ALUOut;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] immGen;
    logic              zero;
    logic              overflow;
    logic              busy;
    logic              done;

    modport master (
        output instruction, instrWrite, PC, dataWrite, regWrite, DOrS,
               ALUSrcA, ALUSrcB, ALUOp, numBits, immShift, start,
        input  ALUOut, A, B, immGen, zero, overflow, busy, done
    );

    modport slave (
        input  instruction, instrWrite, PC, dataWrite, regWrite, DOrS,
               ALUSrcA, ALUSrcB, ALUOp, numBits, immShift, start,
        output ALUOut, A, B, immGen, zero, overflow, busy, done
    );
endinterface

// File: rtl/datapath_exec_unit_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BPC multiplier bits per cycle;
// returns the low DATA_W bits of the product.
module iter_mul
    import datapath_exec_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MUL_BPC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_last,
    output logic [DATA_W-1:0] o_product
);

    localparam int ITERS = DATA_W / MUL_BPC;
    localparam int CNT_W = $clog2(ITERS + 1);

    mul_state_e        r_state;
    mul_state_e        w_state_next;
    logic              w_load;
    logic              w_finish;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [DATA_W-1:0] w_acc_step;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                    w_load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_W'(ITERS - 1)) begin
                    w_state_next = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // One step adds MUL_BPC shifted partial products; the product leaves this
    // combinationally so it lands in ALUOut on the same edge done rises.
    always_comb begin
        w_acc_step = r_acc;
        for (int unsigned k = 0; k < MUL_BPC; k++) begin
            if (r_mplier[k]) begin
                w_acc_step = w_acc_step + (r_mcand << k);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_acc    <= '0;
                r_mcand  <= i_a;
                r_mplier <= i_b;
                r_cnt    <= '0;
            end else if (r_state == ST_RUN) begin
                r_acc    <= w_acc_step;
                r_mcand  <= r_mcand << MUL_BPC;
                r_mplier <= r_mplier >> MUL_BPC;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy    = (r_state == ST_RUN);
    assign o_done    = r_done;
    assign o_last    = w_finish;
    assign o_product = w_acc_step;

endmodule

// File: rtl/datapath_exec_unit.sv
// Multicycle execution datapath: IR, write-through register file, immediate
// generator, A/B latches, ALU with flags, ALUOut and an iterative multiplier.
module datapath_exec_unit
    import datapath_exec_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int MUL_BPC  = 1
) (
    input logic                 CLK,
    input logic                 RST,
    datapath_exec_unit_if.slave bus
);

    localparam int RA_W = $clog2(NUM_REGS);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [IR_W-1:0]   r_ir;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu_out;
    logic              r_ovf;

    logic [RA_W-1:0]   w_rd;
    logic [RA_W-1:0]   w_rs1;
    logic [RA_W-1:0]   w_rs2;
    logic [RA_W-1:0]   w_wr_idx;
    logic              w_wr_en;
    logic              w_unused_ir;
    logic [4:0]        w_imm_w;
    logic [31:0]       w_ir_ext;
    logic [DATA_W-1:0] w_imm_sext;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [SH_W-1:0]   w_shamt;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_ovf;
    logic              w_is_addsub;
    logic              w_is_mul;
    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic              w_mul_last;
    logic [DATA_W-1:0] w_mul_product;

    assign w_rd        = r_ir[11 -: RA_W];
    assign w_rs1       = r_ir[11 - RA_W -: RA_W];
    assign w_rs2       = r_ir[11 - 2*RA_W -: RA_W];
    assign w_unused_ir = ^r_ir[15:12];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ir <= '0;
        end else if (bus.instrWrite) begin
            r_ir <= bus.instruction;
        end
    end

    always_comb begin
        w_imm_w    = imm_width(bus.numBits);
        w_ir_ext   = 32'(r_ir[11:0]);
        w_imm_sext = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            w_imm_sext[i] = (i < 32'(w_imm_w)) ? w_ir_ext[i] : w_ir_ext[w_imm_w - 5'd1];
        end
        w_imm = bus.immShift ? {w_imm_sext[DATA_W-2:0], 1'b0} : w_imm_sext;
    end

    // r0 is never written, so it reads zero from reset onward.
    assign w_wr_idx = bus.DOrS ? w_rs2 : w_rd;
    assign w_wr_en  = bus.regWrite && (w_wr_idx != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_a <= '0;
            r_b <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[w_wr_idx] <= bus.dataWrite;
            end
            r_a <= (w_wr_en && (w_wr_idx == w_rs1)) ? bus.dataWrite : r_regs[w_rs1];
            r_b <= (w_wr_en && (w_wr_idx == w_rs2)) ? bus.dataWrite : r_regs[w_rs2];
        end
    end

    always_comb begin
        w_op_a = bus.ALUSrcA ? bus.PC : r_a;
        case (srcb_e'(bus.ALUSrcB))
            SRCB_B:   w_op_b = r_b;
            SRCB_IMM: w_op_b = w_imm;
            SRCB_TWO: w_op_b = DATA_W'(2);
            default:  w_op_b = '0;
        endcase
    end

    assign w_shamt = w_op_b[SH_W-1:0];

    always_comb begin
        w_sum    = w_op_a + w_op_b;
        w_diff   = w_op_a - w_op_b;
        w_result = '0;
        w_ovf    = 1'b0;
        case (alu_op_e'(bus.ALUOp))
            ALU_ADD: begin
                w_result = w_sum;
                w_ovf    = (w_op_a[MSB] == w_op_b[MSB]) && (w_sum[MSB] != w_op_a[MSB]);
            end
            ALU_SUB: begin
                w_result = w_diff;
                w_ovf    = (w_op_a[MSB] != w_op_b[MSB]) && (w_diff[MSB] != w_op_a[MSB]);
            end
            ALU_AND: w_result = w_op_a & w_op_b;
            ALU_OR:  w_result = w_op_a | w_op_b;
            ALU_XOR: w_result = w_op_a ^ w_op_b;
            ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLL: w_result = w_op_a << w_shamt;
            ALU_SRL: w_result = w_op_a >> w_shamt;
            ALU_SRA: w_result = $unsigned($signed(w_op_a) >>> w_shamt);
            default: w_result = '0;
        endcase
    end

    assign w_is_addsub = (bus.ALUOp == ALU_ADD) || (bus.ALUOp == ALU_SUB);
    assign w_is_mul    = (bus.ALUOp == ALU_MUL);
    assign w_mul_start = bus.start && w_is_mul;

    iter_mul #(
        .DATA_W  (DATA_W),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_start   (w_mul_start),
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_last    (w_mul_last),
        .o_product (w_mul_product)
    );

    // MUL is never a single-cycle result: ALUOut holds from launch until the product lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alu_out <= '0;
            r_ovf     <= 1'b0;
        end else if (w_mul_last) begin
            r_alu_out <= w_mul_product;
        end else if (!w_mul_busy && !w_is_mul) begin
            r_alu_out <= w_result;
            if (w_is_addsub) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign bus.ALUOut   = r_alu_out;
    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.immGen   = w_imm;
    assign bus.zero     = (r_alu_out == '0);
    assign bus.overflow = r_ovf;
    assign bus.busy     = w_mul_busy;
    assign bus.done     = w_mul_done;

endmodule

// File: tb/tb_datapath_exec_unit.sv
// Self-checking bench for datapath_exec_unit (DATA_W=16, NUM_REGS=8, MUL_BPC=1);
// expected ALUOut values go through a scoreboard queue.
module tb_datapath_exec_unit;
    import datapath_exec_pkg::*;

    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    datapath_exec_unit_if #(.DATA_W(DW)) bus ();

    datapath_exec_unit #(
        .DATA_W   (DW),
        .NUM_REGS (8),
        .MUL_BPC  (1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] ir);
        bus.instruction = ir;
        bus.instrWrite  = 1'b1;
        bus.regWrite    = 1'b0;
        tick();
        bus.instrWrite  = 1'b0;
    endtask

    task automatic write_reg(input logic dors, input logic [DW-1:0] val);
        bus.regWrite  = 1'b1;
        bus.DOrS      = dors;
        bus.dataWrite = val;
        tick();
        bus.regWrite  = 1'b0;
    endtask

    // Advance a running MUL until done, recording busy cycles and ALUOut stability.
    task automatic run_mul(input logic [DW-1:0] hold, input int pulse_at,
                           output int busy_cycles, output bit held, output bit got_done);
        busy_cycles = 1;
        held        = 1'b1;
        got_done    = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            bus.start = (cyc == pulse_at);
            bus.ALUOp = (cyc % 2 == 1) ? ALU_MUL : ALU_XOR;
            tick();
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.ALUOut !== hold) held = 1'b0;
        end
        bus.start = 1'b0;
        bus.ALUOp = ALU_ADD;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        checks++;
        if ({bus.ALUOut, bus.A, bus.B, bus.overflow, bus.busy, bus.done, bus.zero} !==
            {16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got out=%h A=%h B=%h ovf=%b busy=%b done=%b zero=%b want 0/0/0/0/0/0/1",
                     bus.ALUOut, bus.A, bus.B, bus.overflow, bus.busy, bus.done, bus.zero);
        end
        checks++;
        if (bus.immGen !== 16'h0) begin
            errors++;
            $display("FAIL reset_imm got %h want 0000", bus.immGen);
        end
    endtask

    task automatic test_imm_path();
        logic [DW-1:0] e;
        bus.PC       = 16'h0000;
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = SRCB_IMM;
        bus.numBits  = 2'd0;
        bus.immShift = 1'b0;
        bus.ALUOp    = ALU_ADD;
        load_ir(16'h0216);
        checks++;
        if (bus.immGen !== 16'h0006) begin
            errors++;
            $display("FAIL imm_path_immgen got %h want 0006", bus.immGen);
        end
        exp_q.push_back(16'h0006);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.ALUOut !== e) begin
            errors++;
            $display("FAIL imm_path_aluout got %h want %h", bus.ALUOut, e);
        end
    endtask

    task automatic test_regfile_alu();
        logic [3:0]    ops  [3];
        logic [DW-1:0] exps [3];
        logic [DW-1:0] e;
        ops  = '{ALU_SUB, ALU_SLT, ALU_ADD};
        exps = '{16'h000A, 16'h0000, 16'h0004};
        load_ir(16'h06E8);
        write_reg(1'b0, 16'h0007);
        write_reg(1'b1, 16'hFFFD);
        checks++;
        if (bus.A !== 16'h0007 || bus.B !== 16'hFFFD) begin
            errors++;
            $display("FAIL regfile_ab got A=%h B=%h want A=0007 B=fffd", bus.A, bus.B);
        end
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = SRCB_B;
        for (int i = 0; i < 3; i++) begin
            bus.ALUOp = ops[i];
            exp_q.push_back(exps[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.ALUOut !== e || bus.zero !== (e == '0)) begin
                errors++;
                $display("FAIL regfile_op%0d got %h zero=%b want %h", ops[i], bus.ALUOut, bus.zero, e);
            end
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL regfile_ovf got %b want 0", bus.overflow);
        end
    endtask

    task automatic test_immediate();
        logic [15:0]   irs  [9];
        logic [1:0]    nbs  [9];
        logic          shs  [9];
        logic [DW-1:0] exps [9];
        irs  = '{16'h0FFE, 16'h0FFE, 16'h0FFE, 16'h0FFE, 16'h07A5, 16'h07A5, 16'h07A5, 16'h07A5, 16'h07A5};
        nbs  = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        shs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exps = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'h0005, 16'hFFE5, 16'hFFA5, 16'h07A5, 16'h0F4A};
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || i == 4) load_ir(irs[i]);
            bus.numBits  = nbs[i];
            bus.immShift = shs[i];
            #1;
            checks++;
            if (bus.immGen !== exps[i]) begin
                errors++;
                $display("FAIL imm_case%0d got %h want %h", i, bus.immGen, exps[i]);
            end
        end
        bus.immShift = 1'b0;
        bus.numBits  = 2'd0;
    endtask

    task automatic test_alu_ops();
        logic [1:0]    srcb [10];
        logic [3:0]    ops  [10];
        logic [DW-1:0] exps [10];
        logic [DW-1:0] e;
        srcb = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        ops  = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_OR, ALU_XOR, ALU_AND, 4'd10, 4'd15, ALU_ADD, ALU_OR};
        exps = '{16'h0002, 16'h4000, 16'hC000, 16'h8001, 16'h8000, 16'h0001, 16'h0000, 16'h0000,
                 16'h8003, 16'h8001};
        load_ir(16'h0001);
        bus.ALUSrcA = 1'b1;
        bus.PC      = 16'h8001;
        for (int i = 0; i < 10; i++) begin
            bus.ALUSrcB = srcb[i];
            bus.ALUOp   = ops[i];
            exp_q.push_back(exps[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.ALUOut !== e) begin
                errors++;
                $display("FAIL alu_case%0d op=%0d got %h want %h", i, ops[i], bus.ALUOut, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] pcs  [5];
        logic [1:0]    srcb [5];
        logic [3:0]    ops  [5];
        logic [DW-1:0] exps [5];
        logic          ovfs [5];
        logic [DW-1:0] e;
        pcs  = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0000};
        srcb = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
        ops  = '{ALU_ADD, ALU_AND, ALU_SUB, ALU_SUB, ALU_ADD};
        exps = '{16'h8000, 16'h0001, 16'h7FFF, 16'h0004, 16'h0000};
        ovfs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.ALUSrcA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.PC      = pcs[i];
            bus.ALUSrcB = srcb[i];
            bus.ALUOp   = ops[i];
            exp_q.push_back(exps[i]);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.ALUOut !== e || bus.overflow !== ovfs[i] || bus.zero !== (e == '0)) begin
                errors++;
                $display("FAIL ovf_case%0d got %h ovf=%b zero=%b want %h ovf=%b",
                         i, bus.ALUOut, bus.overflow, bus.zero, e, ovfs[i]);
            end
        end
    endtask

    task automatic test_write_through();
        load_ir(16'h06E8);
        write_reg(1'b0, 16'h1234);
        checks++;
        if (bus.A !== 16'h1234) begin
            errors++;
            $display("FAIL write_through_a got %h want 1234", bus.A);
        end
        load_ir(16'h0000);
        write_reg(1'b0, 16'h0005);
        checks++;
        if (bus.A !== 16'h0000 || bus.B !== 16'h0000) begin
            errors++;
            $display("FAIL r0_read got A=%h B=%h want 0000", bus.A, bus.B);
        end
    endtask

    task automatic test_mul();
        int            bc;
        bit            held;
        bit            got;
        logic [DW-1:0] e;
        load_ir(16'h06E8);
        write_reg(1'b0, 16'h0007);
        write_reg(1'b1, 16'hFFFD);
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = SRCB_B;
        bus.ALUOp   = ALU_ADD;
        exp_q.push_back(16'h0004);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.ALUOut !== e) begin
            errors++;
            $display("FAIL mul_pre_add got %h want %h", bus.ALUOut, e);
        end
        bus.ALUOp = ALU_MUL;
        bus.start = 1'b1;
        exp_q.push_back(16'hFFEB);
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mul_launch_busy got %b want 1", bus.busy);
        end
        run_mul(16'h0004, 5, bc, held, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL mul_timeout got no done want done within 40 cycles");
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.ALUOut !== e || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_product got %h busy=%b want %h busy=0", bus.ALUOut, bus.busy, e);
        end
        checks++;
        if (bc != 16) begin
            errors++;
            $display("FAIL mul_busy_cycles got %0d want 16", bc);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL mul_aluout_hold got changes want constant 0004");
        end
    endtask

    // Entered in the cycle where done is high: start must launch immediately.
    task automatic test_back_to_back();
        int            bc;
        bit            held;
        bit            got;
        int            extra_done;
        logic [DW-1:0] e;
        bus.ALUOp = ALU_MUL;
        bus.start = 1'b1;
        exp_q.push_back(16'hFFEB);
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_launch got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        run_mul(16'hFFEB, 0, bc, held, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || bus.ALUOut !== e || bc != 16 || !held) begin
            errors++;
            $display("FAIL b2b_mul got done=%b out=%h busy_cycles=%0d held=%b want 1/%h/16/1",
                     got, bus.ALUOut, bc, held, e);
        end
        extra_done = 0;
        exp_q.push_back(16'h0004);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("FAIL done_single_pulse got %0d extra pulses want 0", extra_done);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.ALUOut !== e) begin
            errors++;
            $display("FAIL post_mul_add got %h want %h", bus.ALUOut, e);
        end
    endtask

    task automatic test_start_nonmul();
        bus.ALUOp = ALU_ADD;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_nonmul got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        bus.ALUOp = ALU_MUL;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy got %b want 1", bus.busy);
        end
        RST = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.ALUOut, bus.A, bus.B, bus.overflow} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_state got busy=%b done=%b out=%h A=%h B=%h ovf=%b want all 0",
                     bus.busy, bus.done, bus.ALUOut, bus.A, bus.B, bus.overflow);
        end
        RST = 1'b0;
        bus.ALUOp = ALU_ADD;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rst_mid_done got %0d pulses want 0", dones);
        end
        load_ir(16'h06E8);
        tick();
        checks++;
        if (bus.A !== 16'h0000 || bus.B !== 16'h0000) begin
            errors++;
            $display("FAIL rst_regs_cleared got A=%h B=%h want 0000", bus.A, bus.B);
        end
    endtask

    initial begin
        RST              = 1'b1;
        bus.instruction  = '0;
        bus.instrWrite   = 1'b0;
        bus.PC           = '0;
        bus.dataWrite    = '0;
        bus.regWrite     = 1'b0;
        bus.DOrS         = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = '0;
        bus.ALUOp        = ALU_ADD;
        bus.numBits      = '0;
        bus.immShift     = 1'b0;
        bus.start        = 1'b0;

        test_reset();
        test_imm_path();
        test_regfile_alu();
        test_immediate();
        test_alu_ops();
        test_overflow();
        test_write_through();
        test_mul();
        test_back_to_back();
        test_start_nonmul();
        test_reset_mid_mul();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/datapath_exec_unit.md
Name: datapath_exec_unit

Overview:
Parametrised successor to the step-2 multicycle datapath slice. Contains the instruction register, register file, immediate generator, A/B operand latches, ALU and ALUOut register. Adds configurable data width and register count, a write-through register file, ALU flags, and an iterative multi-cycle multiplier with a start/busy/done handshake. Sits between the fetch/PC logic and the control FSM; the control FSM drives all select lines.

Parameters:
DATA_W, 16, datapath width; even, 8..32
NUM_REGS, 8, register count; power of two, 2..16; RA_W = clog2(NUM_REGS)
MUL_BPC, 1, multiplier bits retired per cycle; 1, 2 or 4; must divide DATA_W

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
instruction  in  16  instruction word to latch
instrWrite  in  1  load IR from instruction
PC  in  DATA_W  program counter
dataWrite  in  DATA_W  register write data
regWrite  in  1  register write enable
DOrS  in  1  write destination: 0 = rd, 1 = rs2
ALUSrcA  in  1  0 = A, 1 = PC
ALUSrcB  in  2  0 = B, 1 = immGen, 2 = constant 2, 3 = zero
ALUOp  in  4  operation code (package)
numBits  in  2  immediate field width: 0→4, 1→6, 2→8, 3→12 bits
immShift  in  1  shift immediate left by 1
start  in  1  launch multi-cycle op (MUL)
ALUOut  out  DATA_W  registered ALU result
A  out  DATA_W  registered operand A
B  out  DATA_W  registered operand B
immGen  out  DATA_W  combinational immediate
zero  out  1  ALUOut == 0
overflow  out  1  registered signed overflow of last ADD/SUB
busy  out  1  multiplier running
done  out  1  one-cycle pulse when MUL result lands

Behaviour:
- Reset (sync, RST=1 at edge): IR, all registers, A, B, ALUOut, overflow ← 0; busy=0, done=0; FSM → IDLE. Applies mid-MUL: op aborted, no done pulse.
- IR fields: rd = IR[11 -: RA_W], rs1 = IR[11-RA_W -: RA_W], rs2 = IR[11-2*RA_W -: RA_W].
- IR loads on edge when instrWrite=1; otherwise holds.
- immGen: IR[w-1:0] with w from numBits, sign-extended to DATA_W, then <<1 if immShift; combinational from IR.
- Register file: r0 reads 0; writes to r0 ignored. Write at edge when regWrite=1 to rd or rs2 per DOrS.
- A ← reg[rs1], B ← reg[rs2] every edge; write-through: same-edge write to the read index → A/B capture dataWrite.
- ALU ops: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5 (signed, result 0/1), SLL 6, SRL 7, SRA 8 (shift amount = low clog2(DATA_W) bits of operand B), MUL 9; codes 10–15 yield 0.
- Single-cycle ops: ALUOut ← result every edge while busy=0. Latency: IR load edge → ALUOut valid after next edge.
- overflow updates only on ADD/SUB edges; holds otherwise.
- FSM IDLE→RUN: edge with start=1, ALUOp=MUL, busy=0. Operands latch from the muxes; busy=1 from that edge.
- RUN: retires MUL_BPC multiplier bits per edge. After DATA_W/MUL_BPC edges: ALUOut ← low DATA_W bits of product (sign-agnostic), done=1 for that cycle, busy=0, → IDLE.
- While busy: ALUOut holds; start and ALUOp changes ignored; register file, IR, A and B still operate.
- start with a non-MUL ALUOp: ignored.
- start in the cycle done=1: busy is already 0, so it launches a new MUL.

Decomposition:
- Package datapath_exec_pkg: ALUOp codes, ALUSrcB codes, FSM state enum {IDLE, RUN}, numBits→width table.
- Sub-module iter_mul: shift-add multiplier, parameters DATA_W and MUL_BPC, ports start/busy/done/product.
- Register file stays inline.

Test Plan:
- RST; instruction=0x0216, instrWrite=1, PC=0, ALUSrcA=1, ALUSrcB=1, numBits=0, ALUOp=ADD → immGen=6 after IR edge; ALUOut=6 one edge later.
- Write r3=7, r5=0xFFFD; IR rs1=3, rs2=5; ALUSrcA=0, ALUSrcB=0: SUB → ALUOut=10; SLT → 0; ADD → 4.
- Immediate: IR[11:0]=0xFFE, numBits=3, immShift=1 → immGen=0xFFFC; numBits=2 gives 0xFFFC too (0xFE<<1).
- MUL 7 × 0xFFFD with MUL_BPC=1 → busy high 16 cycles; done pulses once; ALUOut=0xFFEB. start re-pulsed mid-op is ignored; ALUOut constant until done.
- RST asserted at RUN cycle 5 → next edge busy=0, ALUOut=0, all regs 0; done never pulses.
- Write-through to r3 (0x1234) while rs1=3 → A=0x1234 same edge; write r0=5 → A reads 0. ADD 0x7FFF+1 → ALUOut=0x8000, overflow=1, zero=0.
